// File: rtl/regression_controller.sv
// Sequencer for the linear-regression coefficient datapath: two passes over
// the sample memory (sums, then SSxy/SSxx), a divide wait, then B1/B0 loads.
module regression_controller #(
  parameter int N_SAMPLES = 150,
  parameter int ADDR_W    = 8,
  parameter int DIV_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              en_xy,
  output logic              en_p,
  output logic              clr_p,
  output logic              mean_done,
  output logic              en_ss,
  output logic              clr_ss,
  output logic              en_b1,
  output logic              en_b0
);

  localparam int WCNT_W = $clog2(DIV_WAIT + 1);
  // Truncation is deliberate: with N_SAMPLES == 2**ADDR_W the count wraps to 0 on the last sample.
  localparam logic [ADDR_W-1:0] N_CNT  = ADDR_W'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] N_LAST = ADDR_W'(N_SAMPLES - 1);
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(DIV_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE, INIT1, SUM, INIT2, SSQ, DIV, LDB1, LDB0, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] seq_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE:  if (start) state_d = INIT1;
      INIT1: begin cnt_d = ADDR_W'(1); state_d = SUM; end
      SUM: begin
        if (cnt_q == N_CNT) begin cnt_d = '0; state_d = INIT2; end
        else cnt_d = cnt_q + ADDR_W'(1);
      end
      INIT2: begin cnt_d = ADDR_W'(1); state_d = SSQ; end
      SSQ: begin
        if (cnt_q == N_CNT) begin cnt_d = '0; state_d = DIV; end
        else cnt_d = cnt_q + ADDR_W'(1);
      end
      DIV: begin
        if (wcnt_q == W_LAST) begin wcnt_d = '0; state_d = LDB1; end
        else wcnt_d = wcnt_q + WCNT_W'(1);
      end
      LDB1:    state_d = LDB0;
      LDB0:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Last pass cycle re-reads sample N-1 so the address never leaves the memory.
  assign seq_addr = (cnt_q == N_CNT) ? N_LAST : cnt_q;

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    en_xy     = 1'b0;
    en_p      = 1'b0;
    clr_p     = 1'b0;
    mean_done = 1'b0;
    en_ss     = 1'b0;
    clr_ss    = 1'b0;
    en_b1     = 1'b0;
    en_b0     = 1'b0;
    case (state_q)
      INIT1: begin busy = 1'b1; clr_p = 1'b1; clr_ss = 1'b1; en_xy = 1'b1; end
      SUM: begin
        busy = 1'b1; en_xy = 1'b1; en_p = 1'b1; mem_addr = seq_addr;
      end
      INIT2: begin busy = 1'b1; mean_done = 1'b1; clr_ss = 1'b1; en_xy = 1'b1; end
      SSQ: begin
        busy = 1'b1; mean_done = 1'b1; en_xy = 1'b1; en_ss = 1'b1; mem_addr = seq_addr;
      end
      DIV:     begin busy = 1'b1; mean_done = 1'b1; end
      LDB1:    begin busy = 1'b1; mean_done = 1'b1; en_b1 = 1'b1; end
      LDB0:    begin busy = 1'b1; mean_done = 1'b1; en_b0 = 1'b1; end
      DONE:    begin busy = 1'b1; mean_done = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regression_controller.sv
// Bench for regression_controller (N=4, DIV_WAIT=2) with a real-valued
// datapath model; expected done responses are queued and checked on done.
module tb_regression_controller;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int D  = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, en_xy, en_p, clr_p, mean_done, en_ss, clr_ss, en_b1, en_b0;
  logic [AW-1:0] mem_addr;

  regression_controller #(.N_SAMPLES(N), .ADDR_W(AW), .DIV_WAIT(D)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .en_xy(en_xy), .en_p(en_p), .clr_p(clr_p),
    .mean_done(mean_done), .en_ss(en_ss), .clr_ss(clr_ss),
    .en_b1(en_b1), .en_b0(en_b0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model driven by the controller's enables
  int  xm [8];
  int  ym [8];
  real xr, yr, sx, sy, ssxy, ssxx, b1, b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      xr <= 0.0; yr <= 0.0; sx <= 0.0; sy <= 0.0;
      ssxy <= 0.0; ssxx <= 0.0; b1 <= 0.0; b0 <= 0.0;
    end else begin
      if (en_xy) begin xr <= real'(xm[mem_addr]); yr <= real'(ym[mem_addr]); end
      if (clr_p) begin sx <= 0.0; sy <= 0.0; end
      else if (en_p) begin sx <= sx + xr; sy <= sy + yr; end
      if (clr_ss) begin ssxy <= 0.0; ssxx <= 0.0; end
      else if (en_ss) begin
        ssxy <= ssxy + (xr - sx / N) * (yr - sy / N);
        ssxx <= ssxx + (xr - sx / N) * (xr - sx / N);
      end
      if (en_b1) b1 <= ssxy / ssxx;
      if (en_b0) b0 <= sy / N - b1 * sx / N;
    end
  end

  typedef struct { int done_cyc; real b1; real b0; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_i(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_r(string nm, real act, real exp);
    n_cmp++;
    if (act - exp > 1e-6 || exp - act > 1e-6) begin
      n_bad++;
      $display("FAIL %s: got %f expected %f (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle invariants, plus full response check on each done
  int busy_n = 0, np = 0, nss = 0;
  logic [63:0] trace = '0;
  always @(negedge clk) begin
    if (rst) begin
      busy_n = 0; np = 0; nss = 0; trace = '0;
    end else begin
      if (busy)  busy_n++;
      if (en_p)  np++;
      if (en_ss) nss++;
      if (en_xy) trace = {trace[59:0], 1'b0, mem_addr};
      chk_i("addr_lt_n", longint'(mem_addr < AW'(N)), 1);
      chk_i("en_p_en_ss_excl", longint'(en_p & en_ss), 0);
      chk_i("clr_p_en_p_excl", longint'(clr_p & en_p), 0);
      chk_i("clr_ss_en_ss_excl", longint'(clr_ss & en_ss), 0);
      if (done) begin
        if (sbq.size() == 0) begin
          chk_i("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk_i("done_cycle", cyc, e.done_cyc);
          chk_i("busy_cycles", busy_n, 15);
          chk_i("en_p_cycles", np, N);
          chk_i("en_ss_cycles", nss, N);
          chk_i("addr_trace", longint'(trace), 64'h0123301233);
          chk_i("mean_done_at_done", longint'(mean_done), 1);
          chk_r("b1", b1, e.b1);
          chk_r("b0", b0, e.b0);
        end
        busy_n = 0; np = 0; nss = 0; trace = '0;
      end
    end
  end

  task automatic load(input int x0, x1, x2, x3, y0, y1, y2, y3);
    xm[0] = x0; xm[1] = x1; xm[2] = x2; xm[3] = x3;
    ym[0] = y0; ym[1] = y1; ym[2] = y2; ym[3] = y3;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (sbq.size() != 0 && k < lim) begin @(posedge clk); k++; end
    chk_i("pending_done_timeout", sbq.size(), 0);
    sbq.delete();
  endtask

  // One start pulse; leaves the caller #1 after the edge that entered INIT1
  task automatic pulse_start(input real eb1, input real eb0);
    @(posedge clk); #1;
    start = 1'b1;
    sbq.push_back('{cyc + 15, eb1, eb0});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin xm[i] = 0; ym[i] = 0; end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_busy", busy, 0);
    chk_i("rst_done", done, 0);
    chk_i("rst_mem_addr", mem_addr, 0);
    chk_i("rst_en_xy", en_xy, 0);
    chk_i("rst_clr_p", clr_p, 0);
    chk_i("rst_mean_done", mean_done, 0);
    @(negedge clk) rst = 1'b0;

    // y = 2x + 1
    load(1, 2, 3, 4, 3, 5, 7, 9);
    pulse_start(2.0, 1.0);
    chk_i("init1_busy", busy, 1);
    chk_i("init1_clr_p", clr_p, 1);
    chk_i("init1_clr_ss", clr_ss, 1);
    chk_i("init1_en_xy", en_xy, 1);
    chk_i("init1_addr", mem_addr, 0);
    drain(100);

    // y = 10 - 2x
    load(0, 1, 2, 3, 10, 8, 6, 4);
    pulse_start(-2.0, 10.0);
    drain(100);

    // start held: second run begins two cycles after the first done
    load(2, 4, 6, 8, 1, 2, 3, 4);
    @(posedge clk); #1;
    start = 1'b1;
    sbq.push_back('{cyc + 15, 0.5, 0.0});
    sbq.push_back('{cyc + 31, 0.5, 0.0});
    repeat (20) @(posedge clk);
    #1;
    start = 1'b0;
    drain(100);

    // reset in SSQ with cnt=2, then a clean run
    load(1, 2, 3, 4, 3, 5, 7, 9);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk_i("ssq_en_ss", en_ss, 1);
    chk_i("ssq_addr", mem_addr, 2);
    rst = 1'b1;
    #1;
    chk_i("midrst_busy", busy, 0);
    chk_i("midrst_en_ss", en_ss, 0);
    chk_i("midrst_en_xy", en_xy, 0);
    chk_i("midrst_mean_done", mean_done, 0);
    chk_i("midrst_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    load(0, 1, 2, 3, 10, 8, 6, 4);
    pulse_start(-2.0, 10.0);
    drain(100);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
